// File: rtl/lpf_multi.sv
// Multi-channel hysteresis glitch filter with shared sample prescaler and per-channel rise/fall pulses.
// Optional input synchroniser (2 flops per channel) enabled by defining LPF_MULTI_SYNC_EN.
module lpf_multi #(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned FILTER_SIZE = 4,
    parameter int unsigned ON_THRESH   = (2 ** FILTER_SIZE) - 1,
    parameter int unsigned OFF_THRESH  = 0,
    parameter int unsigned PRESCALE    = 1
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                clr,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out_filt,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    localparam int unsigned MAX_CNT = (2 ** FILTER_SIZE) - 1;
    localparam int unsigned PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [FILTER_SIZE-1:0] CNT_MAX = FILTER_SIZE'(MAX_CNT);
    localparam logic [FILTER_SIZE-1:0] ON_LVL  = FILTER_SIZE'(ON_THRESH);
    localparam logic [FILTER_SIZE-1:0] OFF_LVL = FILTER_SIZE'(OFF_THRESH);
    localparam logic [PS_W-1:0]        PS_LAST = PS_W'(PRESCALE - 1);

    // Reject illegal threshold / prescale combinations at elaboration.
    if (!(OFF_THRESH < ON_THRESH && ON_THRESH <= MAX_CNT && PRESCALE >= 1)) begin : g_cfg_err
        $error("lpf_multi: illegal configuration (need OFF_THRESH < ON_THRESH <= MAX, PRESCALE >= 1)");
    end

    logic [CHANNELS-1:0] in_s;

`ifdef LPF_MULTI_SYNC_EN
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
    end

    // Synchroniser is cleared only by reset, not by clr.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = in;
`endif

    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick_c;

    assign tick_c = (ps_q == PS_LAST);

    always_comb begin
        ps_d = ps_q;
        if (clr || tick_c) begin
            ps_d = '0;
        end else begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    logic [CHANNELS-1:0][FILTER_SIZE-1:0] cntr_q, cntr_d, cntr_n_c;
    logic [CHANNELS-1:0]                  state_q, state_d;
    logic [CHANNELS-1:0]                  rise_q, rise_d;
    logic [CHANNELS-1:0]                  fall_q, fall_d;
    logic                                 any_change_q, any_change_d;

    // Saturating up/down step of every counter, used only on a tick.
    always_comb begin
        cntr_n_c = cntr_q;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (in_s[i] && (cntr_q[i] != CNT_MAX)) begin
                cntr_n_c[i] = cntr_q[i] + FILTER_SIZE'(1);
            end else if (!in_s[i] && (cntr_q[i] != '0)) begin
                cntr_n_c[i] = cntr_q[i] - FILTER_SIZE'(1);
            end
        end
    end

    // Hysteresis state update and edge pulses; clr wins over tick and suppresses pulses.
    always_comb begin
        cntr_d       = cntr_q;
        state_d      = state_q;
        rise_d       = '0;
        fall_d       = '0;
        any_change_d = 1'b0;
        if (clr) begin
            cntr_d  = '0;
            state_d = '0;
        end else if (tick_c) begin
            cntr_d = cntr_n_c;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (!state_q[i] && (cntr_n_c[i] >= ON_LVL)) begin
                    state_d[i] = 1'b1;
                    rise_d[i]  = 1'b1;
                end else if (state_q[i] && (cntr_n_c[i] <= OFF_LVL)) begin
                    state_d[i] = 1'b0;
                    fall_d[i]  = 1'b1;
                end
            end
            any_change_d = |(rise_d | fall_d);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ps_q         <= '0;
            cntr_q       <= '0;
            state_q      <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            any_change_q <= 1'b0;
        end else begin
            ps_q         <= ps_d;
            cntr_q       <= cntr_d;
            state_q      <= state_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            any_change_q <= any_change_d;
        end
    end

    assign out_filt   = state_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign any_change = any_change_q;

endmodule

// File: tb/tb_lpf_multi.sv
// Bench for lpf_multi: two instances (PRESCALE 1 and 4) against a tick-level behavioural model.
module tb_lpf_multi;

    localparam int unsigned CH   = 4;
    localparam int unsigned FS   = 4;
    localparam int          ON   = 12;
    localparam int          OFF  = 3;
    localparam int          MAXC = 15;
`ifdef LPF_MULTI_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic          clk = 1'b0;
    logic          resetN;
    logic          clr;
    logic [CH-1:0] in_drv;

    logic [CH-1:0] of1, r1, f1, of4, r4, f4;
    logic          a1, a4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lpf_multi #(.CHANNELS(CH), .FILTER_SIZE(FS), .ON_THRESH(ON), .OFF_THRESH(OFF), .PRESCALE(1)) u_p1 (
        .clk(clk), .resetN(resetN), .clr(clr), .in(in_drv),
        .out_filt(of1), .rise(r1), .fall(f1), .any_change(a1)
    );

    lpf_multi #(.CHANNELS(CH), .FILTER_SIZE(FS), .ON_THRESH(ON), .OFF_THRESH(OFF), .PRESCALE(4)) u_p4 (
        .clk(clk), .resetN(resetN), .clr(clr), .in(in_drv),
        .out_filt(of4), .rise(r4), .fall(f4), .any_change(a4)
    );

    // Behavioural model: index 0 models PRESCALE=1, index 1 models PRESCALE=4.
    int            m_cnt  [2][CH];
    bit            m_st   [2][CH];
    bit            m_rise [2][CH];
    bit            m_fall [2][CH];
    bit            m_any  [2];
    int            m_cyc  [2];
    logic [CH-1:0] m_s1, m_s2, m_in;

`ifdef LPF_MULTI_SYNC_EN
    assign m_in = m_s2;
`else
    assign m_in = in_drv;
`endif

    function automatic int ps_of(int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic bit tick_of(int d, int cyc);
        return (cyc % ps_of(d)) == (ps_of(d) - 1);
    endfunction

    function automatic int step_cnt(int c, bit x);
        if (x) return (c < MAXC) ? c + 1 : c;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic bit next_st(bit s, int c);
        if (!s && c >= ON) return 1'b1;
        if (s && c <= OFF) return 1'b0;
        return s;
    endfunction

    function automatic bit edge_any(int d);
        bit e = 1'b0;
        for (int i = 0; i < int'(CH); i++)
            if (next_st(m_st[d][i], step_cnt(m_cnt[d][i], m_in[i])) != m_st[d][i]) e = 1'b1;
        return e;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_s1 <= '0;
            m_s2 <= '0;
            for (int d = 0; d < 2; d++) begin
                m_cyc[d] <= 0;
                m_any[d] <= 1'b0;
                for (int i = 0; i < int'(CH); i++) begin
                    m_cnt[d][i]  <= 0;
                    m_st[d][i]   <= 1'b0;
                    m_rise[d][i] <= 1'b0;
                    m_fall[d][i] <= 1'b0;
                end
            end
        end else begin
            m_s1 <= in_drv;
            m_s2 <= m_s1;
            for (int d = 0; d < 2; d++) begin
                m_cyc[d] <= clr ? 0 : m_cyc[d] + 1;
                m_any[d] <= !clr && tick_of(d, m_cyc[d]) && edge_any(d);
                for (int i = 0; i < int'(CH); i++) begin
                    if (clr) begin
                        m_cnt[d][i]  <= 0;
                        m_st[d][i]   <= 1'b0;
                        m_rise[d][i] <= 1'b0;
                        m_fall[d][i] <= 1'b0;
                    end else if (tick_of(d, m_cyc[d])) begin
                        m_cnt[d][i]  <= step_cnt(m_cnt[d][i], m_in[i]);
                        m_st[d][i]   <= next_st(m_st[d][i], step_cnt(m_cnt[d][i], m_in[i]));
                        m_rise[d][i] <= !m_st[d][i] && next_st(m_st[d][i], step_cnt(m_cnt[d][i], m_in[i]));
                        m_fall[d][i] <= m_st[d][i] && !next_st(m_st[d][i], step_cnt(m_cnt[d][i], m_in[i]));
                    end else begin
                        m_rise[d][i] <= 1'b0;
                        m_fall[d][i] <= 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [CH-1:0] pk_st(int d);
        logic [CH-1:0] v;
        for (int i = 0; i < int'(CH); i++) v[i] = m_st[d][i];
        return v;
    endfunction

    function automatic logic [CH-1:0] pk_rise(int d);
        logic [CH-1:0] v;
        for (int i = 0; i < int'(CH); i++) v[i] = m_rise[d][i];
        return v;
    endfunction

    function automatic logic [CH-1:0] pk_fall(int d);
        logic [CH-1:0] v;
        for (int i = 0; i < int'(CH); i++) v[i] = m_fall[d][i];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("p1 out_filt",   32'(of1), 32'(pk_st(0)));
        chk("p1 rise",       32'(r1),  32'(pk_rise(0)));
        chk("p1 fall",       32'(f1),  32'(pk_fall(0)));
        chk("p1 any_change", 32'(a1),  32'(m_any[0]));
        chk("p4 out_filt",   32'(of4), 32'(pk_st(1)));
        chk("p4 rise",       32'(r4),  32'(pk_rise(1)));
        chk("p4 fall",       32'(f4),  32'(pk_fall(1)));
        chk("p4 any_change", 32'(a4),  32'(m_any[1]));
    endtask

    // One clock: compare outputs away from the edge, then return 2ns after the next posedge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #2;
    endtask

    initial begin
        resetN = 1'b0;
        clr    = 1'b0;
        in_drv = '0;
        @(posedge clk);
        #2;
        repeat (3) step();
        chk("reset out_filt", 32'(of1), 32'h0);
        chk("reset any",      32'(a1 | a4), 32'h0);

        // Steady input from cntr=0 rises on the ON-th tick.
        resetN = 1'b1;
        in_drv = 4'b0001;
        repeat (11 + SL) step();
        chk("pre-rise out_filt", 32'(of1), 32'h0);
        step();
        chk("rise out_filt", 32'(of1), 32'h1);
        chk("rise pulse",    32'(r1),  32'h1);
        chk("rise any",      32'(a1),  32'h1);
        chk("rise no fall",  32'(f1),  32'h0);
        step();
        chk("rise one clock", 32'(r1), 32'h0);

        // Short glitch on channel 1.
        in_drv = 4'b0011;
        repeat (5) step();
        in_drv = 4'b0001;
        repeat (5 + SL) step();
        chk("glitch out_filt1", 32'(of1[1]), 32'h0);
        chk("glitch model cnt", 32'(m_cnt[0][1]), 32'h0);

        // Falling hysteresis from saturation.
        in_drv = 4'b0000;
        repeat (11 + SL) step();
        chk("hyst hold", 32'(of1[0]), 32'h1);
        step();
        chk("hyst fall out", 32'(of1[0]), 32'h0);
        chk("hyst fall pulse", 32'(f1), 32'h1);
        chk("hyst fall any", 32'(a1), 32'h1);

        // Re-assert at cntr=5 while ONE keeps the output high.
        in_drv = 4'b0001;
        repeat (20) step();
        in_drv = 4'b0000;
        repeat (10) step();
        in_drv = 4'b0001;
        repeat (8) step();
        chk("reassert hold", 32'(of1[0]), 32'h1);

        // Prescaled simultaneous rise after a clear.
        in_drv = 4'b1111;
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr1 no fall", 32'(f1), 32'h0);
        chk("clr1 out", 32'(of1), 32'h0);
        repeat (47) step();
        chk("p4 pre-rise", 32'(of4), 32'h0);
        step();
        chk("p4 rise out", 32'(of4), 32'hF);
        chk("p4 rise pulse", 32'(r4), 32'hF);
        chk("p4 any", 32'(a4), 32'h1);

        // Clear while all ONE.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr out p1", 32'(of1), 32'h0);
        chk("clr out p4", 32'(of4), 32'h0);
        chk("clr no fall", 32'(f1 | f4), 32'h0);
        chk("clr no any", 32'(a1 | a4), 32'h0);

        // Asynchronous reset mid-count.
        repeat (5) step();
        resetN = 1'b0;
        #1;
        chk("async rst p1", 32'(of1), 32'h0);
        chk("async rst p4", 32'(of4), 32'h0);
        step();
        step();
        resetN = 1'b1;

        // Random phase with occasional clear and reset.
        repeat (3000) begin
            for (int i = 0; i < int'(CH); i++)
                if ($urandom_range(0, 15) == 0) in_drv[i] = ~in_drv[i];
            clr    = ($urandom_range(0, 199) == 0);
            resetN = ($urandom_range(0, 999) != 0);
            step();
        end
        resetN = 1'b1;
        clr    = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lpf_multi.md
# lpf_multi

Multi-channel, parametrised glitch filter for slow external inputs (keyboard lines, buttons, switches) in the VGA/keyboard front end. Each channel has its own saturating up/down counter with separate on/off thresholds for hysteresis. A shared prescaler sets the sample rate. Per-channel rise/fall pulses let game logic react to edges without extra edge detectors.

## Interface
Parameters:
- CHANNELS, 8: number of independent input channels.
- FILTER_SIZE, 4: counter width per channel. MAX = 2^FILTER_SIZE-1.
- ON_THRESH, 2^FILTER_SIZE-1: a channel in state ZERO enters ONE when its updated counter is >= ON_THRESH.
- OFF_THRESH, 0: a channel in state ONE enters ZERO when its updated counter is <= OFF_THRESH.
- PRESCALE, 1: clocks per sample tick. 1 means every clock.
- Legal values: 0 <= OFF_THRESH < ON_THRESH <= MAX and PRESCALE >= 1. Anything else is a configuration error.

Ports (reset resetN, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of all channels
- in  in  CHANNELS  raw inputs
- out_filt  out  CHANNELS  filtered level per channel, registered
- rise  out  CHANNELS  one-clock pulse on a ZERO->ONE transition
- fall  out  CHANNELS  one-clock pulse on a ONE->ZERO transition
- any_change  out  1  OR of rise and fall, registered in the same cycle as those pulses

## Operation
- Prescaler: a counter runs 0..PRESCALE-1 and wraps. `tick` is asserted in the cycle the counter equals PRESCALE-1. With PRESCALE=1, tick is always 1.
- On a tick, each channel i updates independently:
  - in[i]=1 and cntr<MAX: cntr+1.
  - in[i]=0 and cntr>0: cntr-1.
  - Otherwise cntr holds, saturating at MAX and at 0.
- State per channel is ZERO or ONE. Transitions are evaluated on the updated counter value cntr_n:
  - ZERO->ONE when cntr_n >= ON_THRESH.
  - ONE->ZERO when cntr_n <= OFF_THRESH.
  - Otherwise the state holds.
- out_filt[i] equals the registered state.
- rise[i] and fall[i] are registered and assert in the same cycle out_filt[i] changes, for exactly one clock.
- With no tick, counters, states and out_filt hold, and rise, fall and any_change are 0.
- clr=1, synchronous, has priority over tick:
  - all counters go to 0, all states to ZERO, and the prescaler to 0;
  - rise, fall and any_change are forced to 0, so a clear generates no fall pulse.
- Simultaneous edges on several channels each produce their own pulse in the same cycle.

## Timing
- Reset values: cntr=0, state ZERO, prescaler=0, out_filt=0, rise=0, fall=0, any_change=0.
- Reset is asynchronous and may arrive mid-operation. All state clears immediately and no pulses are emitted.
- Input sampled combinationally: an input held steady from cntr=0 raises out_filt at the clock edge of the ON_THRESH-th tick.
- Falling latency from cntr=MAX is (MAX-OFF_THRESH) ticks.
- A glitch shorter than ON_THRESH ticks, starting from cntr=0, never changes out_filt.
- Edge pulses are coincident with the out_filt change, with no extra cycle.

## Configuration
- LPF_MULTI_SYNC_EN defined: each in[i] passes through a 2-flop synchroniser, reset to 0, before the filter. All latencies grow by 2 clocks.
- Not defined: in is used directly. It must already be synchronous to clk.

## Test plan
- CHANNELS=4, FILTER_SIZE=4, ON=12, OFF=3, PRESCALE=1. After reset, hold in=4'b0001 → out_filt=4'b0001 exactly at the 12th clock edge, one-clock rise[0] and any_change, all other outputs 0.
- Glitch: in[1] high for 5 clocks then low → out_filt[1] stays 0, no pulses, counter returns to 0 after 5 more clocks.
- Hysteresis: channel 0 settled high (cntr=15), then in[0]=0. out_filt[0] stays 1 for 11 clocks (cntr=4). On the 12th (cntr=3), out_filt[0]=0 with a one-clock fall[0]. Re-asserting in[0] at cntr=5 keeps out_filt[0]=1.
- PRESCALE=4, in=4'b1111 → all four outputs rise together after 48 clocks. Four simultaneous rise bits, one any_change pulse.
- clr asserted while channels 0-3 are ONE → next clock out_filt=0 with no fall pulse. Reassert resetN low mid-count → outputs 0 asynchronously.
- With LPF_MULTI_SYNC_EN: the first scenario produces the rise at clock 14 instead of 12.
